// File: rtl/mem_access_if.sv
// Execute-side instruction handshake, data-memory bus and register-file write port of mem_access.
// The slave modport is the stage itself; master is whatever drives it (core or bench).
interface mem_access_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_sdata;
    logic [4:0]  in_dst;
    logic [31:0] in_nextpc;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic [31:0] wr;
    logic [4:0]  wa;
    logic        wren;
    logic [31:0] nextpc;
    logic        out_valid;
    logic        err;

    modport slave (
        input  in_valid, in_op, in_addr, in_sdata, in_dst, in_nextpc, mem_ack, mem_rdata,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output wr, wa, wren, nextpc, out_valid, err
    );

    modport master (
        output in_valid, in_op, in_addr, in_sdata, in_dst, in_nextpc, mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  wr, wa, wren, nextpc, out_valid, err
    );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: one instruction at a time, load/store over a req/ack bus, then one register write.
// Define MEM_TIMEOUT_EN to abandon a bus access after TIMEOUT cycles without mem_ack.
module mem_access #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstd,
    mem_access_if.slave bus
);
    localparam logic [2:0] OP_LW  = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_SW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

    // The wait counter is 8 bits wide, so the limit must fit in it.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_access: TIMEOUT must be in 1..255");
    end

    function automatic logic is_load(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        return ((op == OP_LW) || (op == OP_SW)) && (off != 2'd0);
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] off);
        if ((op == OP_LB) || (op == OP_LBU) || (op == OP_SB))
            return 4'b0001 << off;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] load_data(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] rdata);
        logic signed [7:0] b;
        b = rdata[{off, 3'b000} +: 8];
        if (op == OP_LW)
            return rdata;
        if (op == OP_LB)
            return 32'(b);
        return {24'd0, b};
    endfunction

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [4:0]  dst_q;
    logic [31:0] npc_q;
    logic        fail_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_be_q;
    logic [31:0] wr_q, nextpc_q;
    logic [4:0]  wa_q;
    logic        err_q;
    logic        accept, go_bus, ack_bus, timeout;

    assign accept  = (state == IDLE) && bus.in_valid;
    assign go_bus  = accept && (is_load(bus.in_op) || is_store(bus.in_op))
                     && !is_misaligned(bus.in_op, bus.in_addr[1:0]);
    assign ack_bus = (state == BUS) && bus.mem_ack;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Zero outside BUS, so every new access starts counting from 0.
    always_ff @(posedge clk) begin
        if (rstd || state != BUS)
            tmo_cnt <= 8'd0;
        else if (!bus.mem_ack)
            tmo_cnt <= tmo_cnt + 8'd1;
    end

    assign timeout = (state == BUS) && !bus.mem_ack && ((tmo_cnt + 8'd1) == 8'(TIMEOUT));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = (state == IDLE);
        bus.mem_req   = (state == BUS);
        bus.out_valid = (state == DONE);
        bus.wren      = 1'b1;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nxt = go_bus ? BUS : DONE;
            BUS:     if (bus.mem_ack || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if ((state == DONE) && !is_store(op_q) && !fail_q && (wa_q != 5'd0))
            bus.wren = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rstd) begin
            state       <= IDLE;
            op_q        <= 3'd0;
            off_q       <= 2'd0;
            dst_q       <= 5'd0;
            npc_q       <= 32'd0;
            fail_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
            wr_q        <= 32'd0;
            wa_q        <= 5'd0;
            nextpc_q    <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q   <= bus.in_op;
                off_q  <= bus.in_addr[1:0];
                dst_q  <= bus.in_dst;
                npc_q  <= bus.in_nextpc;
                fail_q <= is_misaligned(bus.in_op, bus.in_addr[1:0]);
                if (is_misaligned(bus.in_op, bus.in_addr[1:0]))
                    err_q <= 1'b1;
                if (!is_load(bus.in_op) && !is_store(bus.in_op))
                    wr_q <= bus.in_addr;
            end
            if (go_bus) begin
                mem_we_q    <= is_store(bus.in_op);
                mem_addr_q  <= {bus.in_addr[31:2], 2'b00};
                mem_be_q    <= byte_en(bus.in_op, bus.in_addr[1:0]);
                mem_wdata_q <= (bus.in_op == OP_SB) ? {4{bus.in_sdata[7:0]}} : bus.in_sdata;
            end
            if (ack_bus && is_load(op_q))
                wr_q <= load_data(op_q, off_q, bus.mem_rdata);
            if (timeout) begin
                fail_q <= 1'b1;
                err_q  <= 1'b1;
            end
            // wa/nextpc only change on the way into DONE so they hold steady otherwise.
            if (accept && !go_bus) begin
                wa_q     <= bus.in_dst;
                nextpc_q <= bus.in_nextpc;
            end
            if ((state == BUS) && (state_nxt == DONE)) begin
                wa_q     <= dst_q;
                nextpc_q <= npc_q;
            end
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.wr        = wr_q;
    assign bus.wa        = wa_q;
    assign bus.nextpc    = nextpc_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: transaction-level reference model plus per-cycle compare process.
module tb_mem_access;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rstd = 1'b1;
    always #5 clk = ~clk;

    mem_access_if bus();

    mem_access #(.TIMEOUT(TMO)) dut (
        .clk  (clk),
        .rstd (rstd),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] wr;
        logic [4:0]  wa;
        logic        wren;
        logic [31:0] nextpc;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_err = 0;
    bit          started = 1'b0;
    bit          bus_ok = 1'b0;
    logic        m_err = 1'b0;
    logic [31:0] m_wr = 32'd0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [3:0]  m_be = 4'd0;
    logic        cap_we = 1'b0;
    logic [3:0]  cap_be = 4'd0;
    logic [31:0] cap_wdata = 32'd0;
    int          last_nreq = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Outcome of one instruction straight from the ISA rules; updates sticky err and last wr.
    task automatic model_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input logic [4:0] dst, input logic [31:0] npc,
                             input bit tmo, output exp_t e, output bit mem);
        logic [31:0] off, bv;
        bit ld, st, mis;
        off = addr & 32'd3;
        ld  = (op >= 3'd1) && (op <= 3'd3);
        st  = (op == 3'd4) || (op == 3'd5);
        mis = ((op == 3'd1) || (op == 3'd4)) && (off != 32'd0);
        mem = (ld || st) && !mis;
        if (mis || (mem && tmo)) m_err = 1'b1;
        if (!ld && !st) begin
            m_wr = addr;
        end else if (ld && mem && !tmo) begin
            bv = (rdata >> (off * 32'd8)) & 32'hFF;
            if (op == 3'd1)      m_wr = rdata;
            else if (op == 3'd3) m_wr = bv;
            else                 m_wr = (bv ^ 32'h80) - 32'h80;
        end
        e.wr     = m_wr;
        e.wa     = dst;
        e.nextpc = npc;
        e.err    = m_err;
        e.wren   = !(!st && !mis && !(mem && tmo) && (dst != 5'd0));
        m_we     = st;
        m_addr   = addr & ~32'd3;
        m_be     = ((op == 3'd2) || (op == 3'd3) || (op == 3'd5)) ? 4'(32'd1 << off) : 4'hF;
        m_wdata  = (op == 3'd5) ? (sdata & 32'hFF) * 32'h01010101 : sdata;
    endtask

    // Present one instruction, answer the bus after d idle BUS cycles (or never if tmo), wait for out_valid.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input logic [4:0] dst, input logic [31:0] npc,
                         input int d, input bit tmo);
        exp_t e;
        bit mem, busy_bad;
        int lat, nreq, g, exp_lat;
        model_txn(op, addr, sdata, rdata, dst, npc, tmo, e, mem);
        exp_q.push_back(e);
        bus_ok = mem;
        g = 0;
        while (!bus.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_addr   = addr;
        bus.in_sdata  = sdata;
        bus.in_dst    = dst;
        bus.in_nextpc = npc;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_addr   = ~addr;
        bus.in_sdata  = ~sdata;
        bus.in_dst    = ~dst;
        bus.in_nextpc = ~npc;
        lat = 1;
        nreq = 0;
        busy_bad = 1'b0;
        while (!bus.out_valid && lat < 600) begin
            if (bus.mem_req) begin
                nreq++;
                cap_we    = bus.mem_we;
                cap_be    = bus.mem_be;
                cap_wdata = bus.mem_wdata;
                if (!tmo && nreq == d + 1) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata;
                end
            end
            if (bus.in_ready) busy_bad = 1'b1;
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'h5A5A_5A5A;
            lat++;
        end
        exp_lat = !mem ? 1 : (tmo ? TMO + 1 : d + 2);
        chk("out_valid_seen", 32'(bus.out_valid), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("bus_cycles", 32'(nreq), 32'(!mem ? 0 : (tmo ? TMO : d + 1)));
        chk("in_ready_busy", 32'(busy_bad), 32'd0);
        chk("in_ready_done", 32'(bus.in_ready), 32'd0);
        last_nreq = nreq;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        exp_t e;
        if (started && !rstd) begin
            if (bus.mem_req) begin
                chk("req_expected", 32'(bus_ok), 32'd1);
                chk("mem_we", 32'(bus.mem_we), 32'(m_we));
                chk("mem_addr", bus.mem_addr, m_addr);
                chk("mem_be", 32'(bus.mem_be), 32'(m_be));
                if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
            if (bus.out_valid) begin
                chk("outq_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr", bus.wr, e.wr);
                    chk("wa", 32'(bus.wa), 32'(e.wa));
                    chk("wren", 32'(bus.wren), 32'(e.wren));
                    chk("nextpc", bus.nextpc, e.nextpc);
                    chk("err", 32'(bus.err), 32'(e.err));
                end
            end else begin
                chk("wren_idle", 32'(bus.wren), 32'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_addr   = 32'd0;
        bus.in_sdata  = 32'd0;
        bus.in_dst    = 5'd0;
        bus.in_nextpc = 32'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        rstd = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_wren", 32'(bus.wren), 32'd1);
        chk("rst_wr", bus.wr, 32'd0);
        chk("rst_wa", 32'(bus.wa), 32'd0);
        chk("rst_nextpc", bus.nextpc, 32'd0);
        rstd = 1'b0;
        started = 1'b1;

        issue(3'd0, 32'h1234, 32'd0, 32'd0, 5'd5, 32'h8, 0, 1'b0);
        chk("alu_wr", bus.wr, 32'h1234);
        chk("alu_wa", 32'(bus.wa), 32'd5);
        chk("alu_wren", 32'(bus.wren), 32'd0);
        chk("alu_nextpc", bus.nextpc, 32'h8);

        issue(3'd2, 32'h103, 32'd0, 32'h80FF_FFFF, 5'd6, 32'h10, 3, 1'b0);
        chk("lb_be", 32'(cap_be), 32'b1000);
        chk("lb_wr", bus.wr, 32'hFFFF_FF80);
        chk("lb_bus_cycles", 32'(last_nreq), 32'd4);
        issue(3'd3, 32'h103, 32'd0, 32'h80FF_FFFF, 5'd6, 32'h14, 3, 1'b0);
        chk("lbu_wr", bus.wr, 32'h0000_0080);

        issue(3'd5, 32'h42, 32'h1234_56AB, 32'd0, 5'd9, 32'h18, 1, 1'b0);
        chk("sb_we", 32'(cap_we), 32'd1);
        chk("sb_be", 32'(cap_be), 32'b0100);
        chk("sb_wdata", cap_wdata, 32'hABAB_ABAB);
        chk("sb_wren", 32'(bus.wren), 32'd1);
        chk("sb_err", 32'(bus.err), 32'd0);

        issue(3'd1, 32'h6, 32'd0, 32'd0, 5'd7, 32'h1C, 0, 1'b0);
        chk("mis_err", 32'(bus.err), 32'd1);
        chk("mis_wren", 32'(bus.wren), 32'd1);
        chk("mis_no_req", 32'(last_nreq), 32'd0);
        issue(3'd1, 32'h10, 32'd0, 32'h5555, 5'd0, 32'h20, 0, 1'b0);
        chk("r0_wren", 32'(bus.wren), 32'd1);
        issue(3'd1, 32'h20, 32'd0, 32'h1234_5678, 5'd7, 32'h24, 0, 1'b0);
        chk("lw_wr", bus.wr, 32'h1234_5678);
        chk("lw_wren", 32'(bus.wren), 32'd0);
        issue(3'd4, 32'h24, 32'hCAFE_F00D, 32'd0, 5'd3, 32'h28, 2, 1'b0);
        issue(3'd2, 32'h101, 32'd0, 32'h0000_7F00, 5'd8, 32'h2C, 1, 1'b0);
        chk("lb_pos_wr", bus.wr, 32'h0000_007F);
        issue(3'd6, 32'h99, 32'd0, 32'd0, 5'd3, 32'h30, 0, 1'b0);
        chk("op6_wren", 32'(bus.wren), 32'd0);
        issue(3'd0, 32'hDEAD, 32'd0, 32'd0, 5'd0, 32'h34, 0, 1'b0);
        issue(3'd4, 32'h2, 32'h1, 32'd0, 5'd1, 32'h38, 0, 1'b0);

        // Reset while an access is outstanding, then a stale ack.
        g = 0;
        while (!bus.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        bus_ok = 1'b1;
        m_we = 1'b0;
        m_addr = 32'h30;
        m_be = 4'hF;
        bus.in_valid = 1'b1;
        bus.in_op = 3'd1;
        bus.in_addr = 32'h30;
        bus.in_dst = 5'd4;
        bus.in_nextpc = 32'h3C;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("rst_bus_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        rstd = 1'b1;
        m_err = 1'b0;
        m_wr = 32'd0;
        exp_q.delete();
        @(negedge clk);
        rstd = 1'b0;
        chk("midrst_req", 32'(bus.mem_req), 32'd0);
        chk("midrst_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_err", 32'(bus.err), 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("late_ack_req", 32'(bus.mem_req), 32'd0);
        chk("late_ack_out_valid", 32'(bus.out_valid), 32'd0);
        chk("late_ack_ready", 32'(bus.in_ready), 32'd1);
        chk("late_ack_wr", bus.wr, 32'd0);

`ifdef MEM_TIMEOUT_EN
        issue(3'd1, 32'h40, 32'd0, 32'd0, 5'd9, 32'h44, 0, 1'b1);
        chk("tmo_bus_cycles", 32'(last_nreq), 32'd4);
        chk("tmo_err", 32'(bus.err), 32'd1);
        chk("tmo_wren", 32'(bus.wren), 32'd1);
        chk("tmo_nextpc", bus.nextpc, 32'h44);
`endif

        issue(3'd0, 32'h77, 32'd0, 32'd0, 5'd2, 32'h48, 0, 1'b0);
        chk("post_rst_wr", bus.wr, 32'h77);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
